// File: rtl/mux_sel_reg.sv
// mux_sel_reg: N-way, WIDTH-bit registered selector with valid/ready output.
// Channels are picked either directly by the control unit (mode=0) or by a
// round-robin search over a request vector (mode=1). The chosen word is
// registered into data_out and held until the consumer takes it. A new word
// may replace a word that is being drained in the same cycle.
// Optional feature: define MUX_SEL_ERR_EN to add a sticky sel_err output.
// sel_err flags a direct-mode capture made with an out-of-range selector.
module mux_sel_reg #(
    parameter int WIDTH = 32,
    parameter int N     = 5,
    parameter int SEL_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N*WIDTH-1:0] data_in,
    input  logic               mode,
    input  logic [SEL_W-1:0]   selector,
    input  logic               load,
    input  logic [N-1:0]       req,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   data_out,
    output logic               out_valid,
    output logic [SEL_W-1:0]   out_chan,
`ifdef MUX_SEL_ERR_EN
    output logic               sel_err,
`endif
    output logic [N-1:0]       grant
);

    // Round-robin pointer: the channel granted most recently in mode 1.
    logic [SEL_W-1:0] last;

    logic             can_cap;
    logic             sel_ok;
    logic [SEL_W-1:0] direct_idx;

    logic             hi_found;
    logic [SEL_W-1:0] hi_idx;
    logic             lo_found;
    logic [SEL_W-1:0] lo_idx;
    logic             rr_found;
    logic [SEL_W-1:0] rr_idx;

    logic             do_cap;
    logic [SEL_W-1:0] cap_idx;
    logic [WIDTH-1:0] cap_data;
    logic [N-1:0]     cap_onehot;

    // The output register can take a new word when it is empty or being drained.
    always_comb begin
        can_cap    = !out_valid || out_ready;
        sel_ok     = int'(selector) < N;
        direct_idx = sel_ok ? selector : '0;
    end

    // Round-robin search: the lowest requesting channel above the pointer wins.
    // If there is none, the search wraps and the lowest requesting channel at
    // or below the pointer wins. The loops run downwards so that the last hit
    // they record is the lowest index in each half.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_found = 1'b0;
        lo_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[k]) begin
                if (k > int'(last)) begin
                    hi_found = 1'b1;
                    hi_idx   = SEL_W'(k);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = SEL_W'(k);
                end
            end
        end
        rr_found = hi_found || lo_found;
        rr_idx   = hi_found ? hi_idx : lo_idx;
    end

    // Capture decision and channel index for the current mode.
    always_comb begin
        if (mode) begin
            do_cap  = can_cap && rr_found;
            cap_idx = rr_idx;
        end else begin
            do_cap  = can_cap && load;
            cap_idx = direct_idx;
        end
    end

    // Data multiplexer and one-hot grant for the chosen channel.
    always_comb begin
        cap_data   = '0;
        cap_onehot = '0;
        for (int k = 0; k < N; k++) begin
            if (cap_idx == SEL_W'(k)) begin
                cap_data      = data_in[k*WIDTH +: WIDTH];
                cap_onehot[k] = 1'b1;
            end
        end
    end

    // Output register, handshake state and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_out  <= '0;
            out_valid <= 1'b0;
            out_chan  <= '0;
            grant     <= '0;
            last      <= SEL_W'(N - 1);
        end else begin
            grant <= '0;
            if (do_cap) begin
                data_out  <= cap_data;
                out_valid <= 1'b1;
                out_chan  <= cap_idx;
                grant     <= cap_onehot;
                if (mode) begin
                    last <= cap_idx;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef MUX_SEL_ERR_EN
    // Sticky flag for direct-mode captures made with an out-of-range selector.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sel_err <= 1'b0;
        end else if (do_cap && !mode && !sel_ok) begin
            sel_err <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/mux_sel_reg.md
Name: mux_sel_reg

Overview:
- Parametrised successor to the datapath's fixed 5-way 32-bit selectors.
- An N-way, WIDTH-bit selector with a registered output stage and a valid/ready output handshake.
- Two selection modes: direct select driven by the control unit, and round-robin over a request vector.
- Sits between datapath sources and a consumer that can stall, such as a memory write port or register-bank write-back.

Parameters:
- WIDTH, 32, bit width of each data channel and of data_out.
- N, 5, number of input channels (2..16).
- SEL_W, 3, selector/channel index width; must satisfy 2**SEL_W >= N.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous reset, active-low; sampled on the clk rising edge.
- data_in  input  N*WIDTH  flattened channels; channel k occupies bits [k*WIDTH +: WIDTH].
- mode  input  1  0 = direct select, 1 = round-robin over req.
- selector  input  SEL_W  channel index used in direct mode.
- load  input  1  capture request in direct mode.
- req  input  N  per-channel requests in round-robin mode.
- out_ready  input  1  consumer accepts data_out this cycle.
- data_out  output  WIDTH  registered selected data.
- out_valid  output  1  data_out holds an unconsumed word.
- out_chan  output  SEL_W  index of the channel captured into data_out.
- grant  output  N  one-hot, one-cycle pulse marking the channel captured this cycle.

Behaviour:
- Reset (reset==0 at a clk edge):
  - data_out=0, out_valid=0, out_chan=0, grant=0.
  - Round-robin pointer last=N-1, so the first search starts at channel 0.
  - Reset overrides all other inputs, including a pending word mid-handshake; that word is discarded.
- Capture slot: can_cap = !out_valid || out_ready. With no capture and no drain, out_valid/data_out/out_chan hold.
- Direct mode (mode=0):
  - When load && can_cap: data_out <= channel[selector], out_valid <= 1, out_chan <= selector, grant[selector] pulses for 1 cycle.
  - selector >= N selects channel 0; out_chan=0 and grant[0] pulses.
  - load && !can_cap: no capture, no grant; load is not queued.
  - The round-robin pointer is not updated in direct mode.
- Round-robin mode (mode=1):
  - When can_cap && |req: pick the first set req bit scanning last+1, last+2, ... with wrap N-1 -> 0.
  - Capture that channel as in direct mode and set last <= the picked index.
  - req==0: no capture.
- Latency: 1 cycle from the capture edge to out_valid/data_out visible.
- Drain: out_valid && out_ready with no capture in the same cycle -> out_valid <= 0; data_out holds its last value.
- Simultaneous drain + capture: the new word replaces the old one, out_valid stays 1, no bubble. Back-to-back throughput is 1 word/cycle.
- Mode change: takes effect on the next capture decision. It never disturbs a held word.
- Combinational inputs do not propagate to data_out without a clock edge; there is no combinational path from data_in to data_out.

Optional Feature:
- Macro MUX_SEL_ERR_EN.
- When defined:
  - Adds output sel_err (1 bit, reset 0).
  - sel_err is set sticky when a direct-mode capture occurs with selector >= N.
  - It clears only on reset.
  - The capture of channel 0 still happens as above.
- When undefined: port absent, no extra logic, behaviour otherwise identical.

Test Plan:
- Reset, then direct capture: WIDTH=32, N=5; data_in channel k = 32'hA0+k; reset low 2 cycles; load=1, selector=3, out_ready=0 -> next cycle data_out=32'hA3, out_valid=1, out_chan=3, grant=5'b01000 for exactly 1 cycle.
- Stall: with a word held and out_ready=0, assert load with selector=1 for 4 cycles -> data_out stays 32'hA3 and grant stays 0. Set out_ready=1 with load=0 -> out_valid=0 next cycle.
- Back-to-back: out_ready=1; load=1 with selector 0,1,2,4 on consecutive cycles -> data_out = 32'hA0, A1, A2, A4 on consecutive cycles, out_valid continuously 1.
- Out of range: selector=7 with load -> data_out=32'hA0, out_chan=0. With MUX_SEL_ERR_EN, sel_err=1 and stays 1 until reset.
- Round-robin: mode=1, out_ready=1, req=5'b10110 held -> captured channels 1,2,4,1,2 on successive cycles. Change req to 5'b00001 -> channel 0 next.
- Reset mid-handshake: word held with out_ready=0, then reset low for 1 cycle -> out_valid=0, data_out=0. After reset, mode=1 with req=5'b11111 -> first grant is channel 0.
